// File: rtl/mem_pkg.sv
// Shared encodings and address helpers for the data-side memory access unit.
package mem_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The reserved size code 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_H:    return {lo[1], 1'b0};
            SZ_W:    return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response bundle of the memory access unit.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        addr_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  stall, rdata, rdata_valid, addr_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output stall, rdata, rdata_valid, addr_err
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Lane steering: extracts/extends load data and builds store byte enables and replicated data.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] douta,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result,
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] wdata,
    output logic [3:0]  wea,
    output logic [31:0] dina
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = douta[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? douta[31:16] : douta[15:0];
        case (size)
            SZ_B:    result = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    result = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: result = douta;
        endcase
    end

    // Narrow stores replicate the datum across every lane; byte enables pick the real one.
    always_comb begin
        case (st_size)
            SZ_B: begin
                wea  = 4'b0001 << st_addr_lo;
                dina = {4{wdata[7:0]}};
            end
            SZ_H: begin
                wea  = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                dina = {2{wdata[15:0]}};
            end
            default: begin
                wea  = 4'b1111;
                dina = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-side memory stage: stores in one cycle, loads stall the core across RAM latency.
// Optional macro MEM_MISALIGN_EXC_EN: flag misaligned accesses instead of force-aligning them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  core,
    output logic              ram_ena,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta
);

    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    state_t      state, state_nx;
    logic [1:0]  wait_cnt;
    logic [1:0]  cap_lo, cap_size;
    logic        cap_uns;
    logic [31:0] rdata_q, ld_result, st_dina;
    logic [3:0]  st_wea;
    logic [1:0]  size_n, req_lo;
    logic        misaligned;
    logic        stall_c, valid_c, err_c, issue_load, take_data;
    logic        unused_addr_hi;

    assign size_n         = norm_size(core.req_size);
    assign unused_addr_hi = ^core.req_addr[31:ADDR_W+2];

`ifdef MEM_MISALIGN_EXC_EN
    assign misaligned = is_misaligned(size_n, core.req_addr[1:0]);
    assign req_lo     = core.req_addr[1:0];
`else
    assign misaligned = 1'b0;
    assign req_lo     = align_lo(size_n, core.req_addr[1:0]);
`endif

    load_align u_align (
        .douta       (ram_douta),
        .addr_lo     (cap_lo),
        .size        (cap_size),
        .is_unsigned (cap_uns),
        .result      (ld_result),
        .st_addr_lo  (req_lo),
        .st_size     (size_n),
        .wdata       (core.req_wdata),
        .wea         (st_wea),
        .dina        (st_dina)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Outputs are gated while reset is low so an aborted load releases the core at once.
    always_comb begin
        state_nx   = state;
        ram_ena    = 1'b0;
        ram_wea    = 4'b0000;
        stall_c    = 1'b0;
        valid_c    = 1'b0;
        err_c      = 1'b0;
        issue_load = 1'b0;
        take_data  = 1'b0;
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    if (core.req_valid) begin
                        if (misaligned) begin
                            err_c = 1'b1;
                        end else if (core.req_we) begin
                            ram_ena = 1'b1;
                            ram_wea = st_wea;
                        end else begin
                            ram_ena    = 1'b1;
                            stall_c    = 1'b1;
                            issue_load = 1'b1;
                            state_nx   = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    ram_ena = 1'b1;
                    stall_c = 1'b1;
                    if (wait_cnt == LAT_LAST) begin
                        take_data = 1'b1;
                        state_nx  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_c  = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 2'd0;
            cap_lo   <= 2'b00;
            cap_size <= SZ_B;
            cap_uns  <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            if (issue_load) begin
                wait_cnt <= 2'd0;
                cap_lo   <= req_lo;
                cap_size <= size_n;
                cap_uns  <= core.req_unsigned;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            if (take_data) rdata_q <= ld_result;
        end
    end

    assign ram_addr         = core.req_addr[ADDR_W+1:2];
    assign ram_dina         = st_dina;
    assign core.stall       = stall_c;
    assign core.rdata       = rdata_q;
    assign core.rdata_valid = valid_c;
    assign core.addr_err    = err_c;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-side memory stage between the mips core and the single-port synchronous data_ram.
- Turns core load/store requests (byte/half/word, signed/unsigned) into RAM byte-enables and word addresses.
- Stalls the core across RAM read latency, then returns aligned, extended load data.
- Stores complete in one cycle; loads take RAM_LAT+1 stall cycles.

Parameters:
- ADDR_W, 10, RAM word-address width; ram_addr = req_addr[ADDR_W+1:2].
- RAM_LAT, 1, RAM read latency in cycles (legal 1..2): douta is valid RAM_LAT cycles after the enable cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core memory access this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extend (1) / sign-extend (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  core must hold all req_* stable while 1
- rdata  out  32  extended load result
- rdata_valid  out  1  one-cycle pulse, rdata valid
- addr_err  out  1  misaligned access pulse (see Optional Feature)
- ram_ena  out  1  RAM enable
- ram_wea  out  4  RAM byte write enables, bit i = byte lane i (little-endian)
- ram_addr  out  ADDR_W  RAM word address
- ram_dina  out  32  RAM write data
- ram_douta  in  32  RAM read data

Behaviour:
- Reset (rst=0, async): state IDLE, wait counter 0, rdata 0, rdata_valid 0, stall 0, addr_err 0, ram_ena 0, ram_wea 0.
- FSM states: IDLE, WAIT, DONE. New requests are accepted only in IDLE.
- Store in IDLE, issued the same cycle combinationally:
  - ram_ena=1; ram_wea per size/addr[1:0]: byte -> 1<<a; half -> 0011 or 1100; word -> 1111.
  - ram_dina: byte replicated x4, half replicated x2, word as-is.
  - stall=0; state stays IDLE.
- Load in IDLE (cycle T):
  - ram_ena=1, ram_wea=0, stall=1; capture addr[1:0], size and unsigned into registers; counter=0; go to WAIT.
- WAIT:
  - ram_ena=1, ram_addr held from the core, stall=1; counter increments.
  - When counter==RAM_LAT-1, register the extracted ram_douta into rdata and go to DONE.
- DONE (cycle T+RAM_LAT+1): rdata_valid=1, stall=0, ram_ena=0; next state IDLE. A req_valid seen in DONE is the same load and is ignored.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend from bit 7/15 unless unsigned. Word passes through.
- rdata holds its value until the next load completes. rdata_valid is a one-cycle pulse.
- req_valid=0 in IDLE: ram_ena=0, no state change.
- Reset asserted mid-load aborts to IDLE; no rdata_valid is produced.
- Back-to-back loads: the second load issues in the IDLE cycle after DONE. There is no bubble beyond the FSM.

Optional Feature:
- Macro: MEM_MISALIGN_EXC_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - Misaligned access: addr_err=1 combinationally in the request cycle; no RAM access (ram_ena=0, ram_wea=0); stall=0; state stays IDLE; rdata unchanged.
- Undefined: addr_err tied 0; low address bits below the access size are forced to zero (force-align), and the access proceeds normally.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - FSM state encodings ST_IDLE, ST_WAIT, ST_DONE;
  - the default ADDR_W.
- One combinational sub-module, load_align: (douta, addr_lo, size, unsigned) -> extended 32-bit result. Also reused for the store lane/byte-enable generation function.

Test Plan:
- Store: sb addr 0x0000_0006, wdata 0x0000_00A5 -> ram_wea=0100, ram_addr=1, ram_dina=A5A5A5A5, stall 0.
- Load: after mem[1]=0x80FF_7F01, signed lb addr 0x7 -> rdata=FFFF_FF80; lbu addr 0x7 -> 0000_0080. rdata_valid pulses at cycle T+2 (RAM_LAT=1); stall high for exactly 2 cycles.
- Load: RAM_LAT=2, lh addr 0x4 with mem[1]=0x1234_8001 -> rdata=FFFF_8001; stall high 3 cycles; ram_addr held for the full wait.
- Back-to-back: lw 0x8 then lw 0xC -> two rdata_valid pulses, separated by RAM_LAT+1 cycles; no extra idle cycle.
- Reset: rst low during WAIT -> stall=0 immediately, no rdata_valid, rdata=0; next lw completes normally.
- Misaligned: lw addr 0x2 -> with MEM_MISALIGN_EXC_EN: addr_err=1, ram_ena=0, stall=0. Without the macro: reads word 0, returns mem[0].
